mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  N-to-1 memory request arbiter replacing the fixed imem/dmem split: NUM_PORTS requesters
//  (same req/res handshake as MemoryIn/MemoryOut) share one memory port. Round-robin grant,
//  in-order response routing via a tag FIFO holding up to MAX_OUT outstanding requests.
//  Sits between the core fetch/LSU ports and the single-ported memory model.
// PARAMETERS
//  NUM_PORTS  2   number of requester ports (>=2)
//  ADDR_W     32  request address width
//  DATA_W     32  request/response data width
//  MAX_OUT    4   max outstanding requests (tag FIFO depth, power of 2, >=2)
// PORTS
//  clk            in   1                  clock, all state on rising edge
//  reset          in   1                  synchronous, active-high
//  p_req_valid    in   NUM_PORTS          per-port request valid
//  p_req_addr     in   NUM_PORTS*ADDR_W   per-port addr, port i at [i*ADDR_W +: ADDR_W]
//  p_req_data     in   NUM_PORTS*DATA_W   per-port write data
//  p_req_fcn      in   NUM_PORTS*2        per-port MemoryWriteSignal (M_XRD/M_XWR)
//  p_req_typ      in   NUM_PORTS*3        per-port MemoryMaskType
//  p_req_ready    out  NUM_PORTS          request accepted this cycle (one-hot or zero)
//  p_res_valid    out  NUM_PORTS          response valid for port i (one-hot or zero)
//  p_res_data     out  DATA_W             response data, shared by all ports
//  m_req_valid    out  1                  downstream request valid
//  m_req_addr/data/fcn/typ  out  ADDR_W/DATA_W/2/3  muxed request fields of granted port
//  m_req_ready    in   1                  downstream accepts request
//  m_res_valid    in   1                  downstream response (exactly one per request, in order)
//  m_res_data     in   DATA_W             downstream response data
//  outstanding    out  $clog2(MAX_OUT)+1  current outstanding count
//  err_orphan     out  1                  sticky: response arrived with no outstanding request
// BEHAVIOUR
//  - Reset: rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0; hence m_req_valid=0,
//    p_req_ready=0, p_res_valid=0. Reset mid-transaction discards all outstanding tags.
//  - Grant (comb): gnt = first i with p_req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N.
//  - full = (outstanding==MAX_OUT). m_req_valid = |p_req_valid & !full; m_req_* = port gnt fields.
//  - p_req_ready[gnt] = m_req_ready & !full; all others 0. Fire = m_req_valid & m_req_ready.
//  - On fire: push gnt to tag FIFO; rr_ptr <= (gnt+1) mod N. No fire: rr_ptr holds.
//  - Grant may change while m_req_valid stays high without m_req_ready (no lock);
//    requesters must hold valid/fields until their p_req_ready.
//  - Response: m_res_valid & !empty -> pop head; p_res_valid[head]=1 same cycle (0-cycle comb
//    path), p_res_data=m_res_data always. m_res_valid & empty -> ignored, err_orphan<=1.
//  - Full: no grant even if a response pops same cycle (no bypass); request fires next cycle.
//  - Simultaneous fire + pop: outstanding unchanged; FIFO pointers wrap mod MAX_OUT.
//  - Writes (M_XWR) also receive one response; fcn/typ passed through unmodified.
//  - outstanding = pushes - pops since reset, range 0..MAX_OUT.
// TESTING
//  1 Reset: reset=1 2 cycles, all valids high -> m_req_valid=0, outstanding=0, err_orphan=0.
//  2 Round-robin: N=2, both valid, m_req_ready=1 4 cycles -> grants 0,1,0,1; tags 0,1,0,1.
//  3 Routing: port0 read 0x100, port1 read 0x200, mem responds 0xAAAA then 0xBBBB
//    -> p_res_valid=01 with 0xAAAA, then 10 with 0xBBBB.
//  4 Full: MAX_OUT=4, 4 fires, no responses -> m_req_valid=0, p_req_ready=0 while port valid;
//    one response -> next cycle request fires, outstanding back to 4.
//  5 Orphan: m_res_valid=1 with FIFO empty -> no p_res_valid, err_orphan=1 and stays 1.
//  6 Fire+pop same cycle at outstanding=2 -> outstanding stays 2, correct head port routed.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NUM_PORTS requesters share a single memory port.
// Requests are granted round-robin. Responses come back in order and are
// routed to their requester through a tag FIFO that holds up to MAX_OUT
// outstanding requests.
//
// Handshake: a request transfers when valid and ready are both high in the
// same cycle. A requester must hold its valid and fields until it sees its
// p_req_ready. The memory side signals ready without waiting for valid.
// m_res_valid is a one-cycle pulse with no back-pressure, and each request
// gets exactly one response.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          p_req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_req_data,
    input  logic [NUM_PORTS*2-1:0]        p_req_fcn,
    input  logic [NUM_PORTS*3-1:0]        p_req_typ,
    output logic [NUM_PORTS-1:0]          p_req_ready,
    output logic [NUM_PORTS-1:0]          p_res_valid,
    output logic [DATA_W-1:0]             p_res_data,
    output logic                          m_req_valid,
    output logic [ADDR_W-1:0]             m_req_addr,
    output logic [DATA_W-1:0]             m_req_data,
    output logic [1:0]                    m_req_fcn,
    output logic [2:0]                    m_req_typ,
    input  logic                          m_req_ready,
    input  logic                          m_res_valid,
    input  logic [DATA_W-1:0]             m_res_data,
    output logic [$clog2(MAX_OUT):0]      outstanding,
    output logic                          err_orphan
);

    localparam int TAG_W = $clog2(NUM_PORTS);
    localparam int FW    = $clog2(MAX_OUT);
    localparam int CNT_W = FW + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] gnt;
    logic [TAG_W-1:0] idx;
    logic             found;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] tag_mem [MAX_OUT];
    logic [FW-1:0]    wr_ptr;
    logic [FW-1:0]    rd_ptr;
    logic             any_valid;
    logic             full;
    logic             empty;
    logic             fire;
    logic             pop;

    assign any_valid = |p_req_valid;
    assign full      = (outstanding == CNT_W'(MAX_OUT));
    assign empty     = (outstanding == '0);
    // Outputs are held quiet while reset is asserted, even though they are combinational.
    assign m_req_valid = any_valid & ~full & ~reset;
    assign fire        = m_req_valid & m_req_ready;
    assign pop         = m_res_valid & ~empty & ~reset;
    assign head_tag    = tag_mem[rd_ptr];
    assign p_res_data  = m_res_data;

    // Round-robin search: the first valid port at or after rr_ptr, wrapping.
    always_comb begin
        gnt   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = TAG_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!found && p_req_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    // Steer the granted port's fields downstream, and fan out ready and response valid.
    always_comb begin
        m_req_addr  = '0;
        m_req_data  = '0;
        m_req_fcn   = '0;
        m_req_typ   = '0;
        p_req_ready = '0;
        p_res_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt == TAG_W'(i)) begin
                m_req_addr = p_req_addr[i*ADDR_W +: ADDR_W];
                m_req_data = p_req_data[i*DATA_W +: DATA_W];
                m_req_fcn  = p_req_fcn[i*2 +: 2];
                m_req_typ  = p_req_typ[i*3 +: 3];
            end
            p_req_ready[i] = (gnt == TAG_W'(i)) & m_req_valid & m_req_ready;
            p_res_valid[i] = pop & (head_tag == TAG_W'(i));
        end
    end

    // Tag storage. Its contents are only read behind rd_ptr, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr] <= gnt;
        end
    end

    // Pointers, outstanding count, round-robin pointer and the sticky orphan flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gnt == TAG_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fire && !pop) begin
                outstanding <= outstanding + 1'b1;
            end else if (pop && !fire) begin
                outstanding <= outstanding - 1'b1;
            end
            if (m_res_valid && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Directed reset, round-robin, full,
// drain and orphan sequences are followed by randomized traffic and a
// reset in the middle of traffic. A reference model tracks a queue of
// requester ids and a round-robin pointer.
module tb_mem_port_arbiter;
    localparam int N       = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = $clog2(MAX_OUT) + 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N-1:0]             p_req_valid;
    logic [N*ADDR_W-1:0]      p_req_addr;
    logic [N*DATA_W-1:0]      p_req_data;
    logic [N*2-1:0]           p_req_fcn;
    logic [N*3-1:0]           p_req_typ;
    logic [N-1:0]             p_req_ready;
    logic [N-1:0]             p_res_valid;
    logic [DATA_W-1:0]        p_res_data;
    logic                     m_req_valid;
    logic [ADDR_W-1:0]        m_req_addr;
    logic [DATA_W-1:0]        m_req_data;
    logic [1:0]               m_req_fcn;
    logic [2:0]               m_req_typ;
    logic                     m_req_ready;
    logic                     m_res_valid;
    logic [DATA_W-1:0]        m_res_data;
    logic [CNT_W-1:0]         outstanding;
    logic                     err_orphan;

    // Per-port request fields, packed onto the flat ports below.
    logic [ADDR_W-1:0] addr_a [N];
    logic [DATA_W-1:0] data_a [N];
    logic [1:0]        fcn_a  [N];
    logic [2:0]        typ_a  [N];
    logic [N-1:0]      last_acc;

    // Reference model state.
    logic [7:0] exp_q[$];
    int         m_rr;
    bit         m_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .p_req_valid(p_req_valid), .p_req_addr(p_req_addr), .p_req_data(p_req_data),
        .p_req_fcn(p_req_fcn), .p_req_typ(p_req_typ), .p_req_ready(p_req_ready),
        .p_res_valid(p_res_valid), .p_res_data(p_res_data),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ), .m_req_ready(m_req_ready),
        .m_res_valid(m_res_valid), .m_res_data(m_res_data),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    // Clock and reset
    always #5 clk = ~clk;

    always_comb begin
        p_req_addr = '0;
        p_req_data = '0;
        p_req_fcn  = '0;
        p_req_typ  = '0;
        for (int i = 0; i < N; i++) begin
            p_req_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
            p_req_data[i*DATA_W +: DATA_W] = data_a[i];
            p_req_fcn[i*2 +: 2]            = fcn_a[i];
            p_req_typ[i*3 +: 3]            = typ_a[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver: give a port new random fields.
    task automatic new_req(input int i, input bit v);
        p_req_valid[i] = v;
        addr_a[i] = $urandom;
        data_a[i] = $urandom;
        fcn_a[i]  = 2'($urandom_range(0, 1));
        typ_a[i]  = 3'($urandom_range(0, 7));
    endtask

    // Driver: random traffic that honours the hold-until-ready rule.
    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (!p_req_valid[i] || last_acc[i]) new_req(i, $urandom_range(0, 3) != 0);
        end
        m_req_ready = $urandom_range(0, 3) != 0;
        m_res_valid = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
        m_res_data  = $urandom;
    endtask

    // One cycle: inputs are already driven at posedge+1. Compare at posedge+5,
    // then advance the model across the clock edge.
    task automatic step();
        int           g;
        bit           any;
        bit           full;
        bit           fire;
        bit           pop;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_res;
        #4;
        if (reset) begin
            check("rst_m_req_valid", 64'(m_req_valid), 64'd0);
            check("rst_p_req_ready", 64'(p_req_ready), 64'd0);
            check("rst_p_res_valid", 64'(p_res_valid), 64'd0);
            check("rst_outstanding", 64'(outstanding), 64'(exp_q.size()));
            check("rst_err_orphan", 64'(err_orphan), 64'(m_err));
            @(posedge clk); #1;
            exp_q.delete();
            m_rr     = 0;
            m_err    = 0;
            last_acc = '0;
            return;
        end
        any = |p_req_valid;
        g = m_rr;
        for (int k = N - 1; k >= 0; k--) begin
            if (p_req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        full  = exp_q.size() == MAX_OUT;
        fire  = any && !full && m_req_ready;
        pop   = m_res_valid && exp_q.size() > 0;
        e_rdy = fire ? N'(1 << g) : '0;
        e_res = pop ? N'(1 << exp_q[0]) : '0;
        check("m_req_valid", 64'(m_req_valid), 64'(any && !full));
        check("p_req_ready", 64'(p_req_ready), 64'(e_rdy));
        check("p_res_valid", 64'(p_res_valid), 64'(e_res));
        check("p_res_data", 64'(p_res_data), 64'(m_res_data));
        check("outstanding", 64'(outstanding), 64'(exp_q.size()));
        check("err_orphan", 64'(err_orphan), 64'(m_err));
        if (any && !full) begin
            check("m_req_addr", 64'(m_req_addr), 64'(addr_a[g]));
            check("m_req_data", 64'(m_req_data), 64'(data_a[g]));
            check("m_req_fcn_typ", 64'({m_req_fcn, m_req_typ}), 64'({fcn_a[g], typ_a[g]}));
        end
        @(posedge clk); #1;
        if (m_res_valid && exp_q.size() == 0) m_err = 1;
        if (pop) void'(exp_q.pop_front());
        if (fire) begin
            exp_q.push_back(8'(g));
            m_rr = (g + 1) % N;
        end
        last_acc = e_rdy;
    endtask

    initial begin
        reset       = 1'b1;
        p_req_valid = '1;
        m_req_ready = 1'b1;
        m_res_valid = 1'b0;
        m_res_data  = '0;
        last_acc    = '0;
        m_rr        = 0;
        m_err       = 0;
        for (int i = 0; i < N; i++) new_req(i, 1'b1);
        @(posedge clk); #1;
        // Reset held with every port requesting.
        step();
        step();
        reset = 1'b0;

        // Round-robin with both ports always requesting. The queue fills to MAX_OUT.
        for (int c = 0; c < MAX_OUT; c++) begin
            for (int i = 0; i < N; i++) if (last_acc[i]) new_req(i, 1'b1);
            step();
        end
        check("rr_fill_count", 64'(outstanding), 64'(MAX_OUT));
        check("rr_tag_order", 64'({exp_q[0], exp_q[1], exp_q[2], exp_q[3]}), 64'h00010001);

        // While full, nothing is granted. A pop in that cycle does not bypass the full check.
        for (int i = 0; i < N; i++) if (last_acc[i]) new_req(i, 1'b1);
        step();
        m_res_valid = 1'b1;
        m_res_data  = 32'hAAAA;
        step();
        m_res_valid = 1'b0;
        step();
        check("refill_count", 64'(outstanding), 64'(MAX_OUT));

        // Drain with no requests, then a response that has no request behind it.
        p_req_valid = '0;
        m_res_valid = 1'b1;
        for (int c = 0; c < MAX_OUT; c++) begin
            m_res_data = $urandom;
            step();
        end
        step();
        m_res_valid = 1'b0;
        step();
        check("orphan_sticky", 64'(err_orphan), 64'd1);

        // Randomized traffic, with a reset while requests are outstanding.
        for (int c = 0; c < 1500; c++) begin
            drive_random();
            if (c == 700) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        check("final_count", 64'(outstanding), 64'(exp_q.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
